// File: rtl/dff_mon_pkg.sv
// Shared constants and FSM state type for the DFF bank monitor.
package dff_mon_pkg;

  localparam int Q_WIDTH   = 64;
  localparam int FRAME_LEN = 9;
  localparam int NUM_BYTES = FRAME_LEN - 1;
  localparam int DROP_MAX  = 255;
  localparam int IDX_W     = 3;
  localparam int POP_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

endpackage

// File: rtl/popcount64.sv
// Purely combinational population count of a 64-bit word.
module popcount64
  import dff_mon_pkg::*;
(
  input  logic [63:0]      din,
  output logic [POP_W-1:0] cnt
);

  logic [1:0] pair_sum [32];

  // First level pairs adjacent bits; the final sum is done in one reduction loop.
  for (genvar gi = 0; gi < 32; gi++) begin : g_pair
    assign pair_sum[gi] = {1'b0, din[2*gi]} + {1'b0, din[2*gi+1]};
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + POP_W'(pair_sum[i]);
    end
  end

endmodule

// File: rtl/dff_bank_monitor.sv
// Snapshots a 64-bit DFF bank on request and streams it out as a 9-byte frame:
// one header byte (changed-bit count plus drop flag) followed by 8 data bytes.
module dff_bank_monitor
  import dff_mon_pkg::*;
#(
  parameter int Q_WIDTH = dff_mon_pkg::Q_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [Q_WIDTH-1:0] q_in,
  input  logic               sample,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [7:0]         drop_cnt
);

  state_t             state_q, state_d;
  logic [Q_WIDTH-1:0] snap_q, snap_d;
  logic [Q_WIDTH-1:0] prev_q, prev_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               drop_flag_q, drop_flag_d;
  logic               hdr_flag_q, hdr_flag_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic [POP_W-1:0]   change_cnt;
  logic               xfer;

  // Header count is taken between the current snapshot and the one before it.
  popcount64 u_popcount (
    .din (snap_q ^ prev_q),
    .cnt (change_cnt)
  );

  assign busy     = (state_q != ST_IDLE);
  assign tx_valid = busy;
  assign drop_cnt = drop_cnt_q;
  assign xfer     = busy && tx_ready;

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    prev_d      = prev_q;
    idx_d       = idx_q;
    drop_flag_d = drop_flag_q;
    hdr_flag_d  = hdr_flag_q;
    drop_cnt_d  = drop_cnt_q;

    if (sample) begin
      if (state_q == ST_IDLE) begin
        snap_d      = q_in;
        prev_d      = snap_q;
        hdr_flag_d  = drop_flag_q;
        drop_flag_d = 1'b0;
        idx_d       = '0;
        state_d     = ST_HEADER;
      end else begin
        drop_flag_d = 1'b1;
        if (drop_cnt_q != 8'(DROP_MAX)) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
    end

    case (state_q)
      ST_IDLE: ;
      ST_HEADER: begin
        if (xfer) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output byte is a pure function of flops, so it cannot move while stalled.
  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      ST_HEADER: tx_data = {hdr_flag_q, change_cnt};
      ST_DATA:   tx_data = snap_q[{idx_q, 3'b000} +: 8];
      default:   tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      prev_q      <= '0;
      idx_q       <= '0;
      drop_flag_q <= 1'b0;
      hdr_flag_q  <= 1'b0;
      drop_cnt_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      prev_q      <= prev_d;
      idx_q       <= idx_d;
      drop_flag_q <= drop_flag_d;
      hdr_flag_q  <= hdr_flag_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_dff_bank_monitor.sv
// Directed bench with a byte scoreboard: expected frame bytes are queued when a
// sample is accepted and compared as each byte is transferred.
module tb_dff_bank_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] q_in;
  logic        sample;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_q[$];
  logic [63:0] m_snap;
  logic        m_flag;
  int          m_cnt;
  int          n;

  always #5 clk = ~clk;

  dff_bank_monitor #(.Q_WIDTH(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .q_in     (q_in),
    .sample   (sample),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare at the falling edge, update the model, then
  // return 1 time unit after the rising edge so the caller can drive inputs.
  task automatic step();
    logic busy_now;
    logic [7:0] hdr;
    @(negedge clk);
    busy_now = (exp_q.size() != 0);
    check("tx_valid", {7'd0, tx_valid}, {7'd0, busy_now});
    check("busy", {7'd0, busy}, {7'd0, busy_now});
    check("drop_cnt", drop_cnt, 8'(m_cnt));
    if (busy_now) check("tx_data", tx_data, exp_q[0]);
    if (rst) begin
      exp_q.delete();
      m_snap = '0;
      m_flag = 1'b0;
      m_cnt  = 0;
    end else begin
      if (busy_now && tx_ready) begin
        $display("byte %02h transferred, %0d left", exp_q[0], exp_q.size() - 1);
        void'(exp_q.pop_front());
      end
      if (sample) begin
        if (busy_now) begin
          if (m_cnt < 255) m_cnt++;
          m_flag = 1'b1;
        end else begin
          hdr = {m_flag, 7'($countones(q_in ^ m_snap))};
          exp_q.push_back(hdr);
          for (int i = 0; i < 8; i++) exp_q.push_back(q_in[8*i +: 8]);
          $display("sample accepted q_in=%016h header=%02h", q_in, hdr);
          m_snap = q_in;
          m_flag = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sample(input logic [63:0] q);
    q_in   = q;
    sample = 1'b1;
    step();
    sample = 1'b0;
  endtask

  task automatic drain(input int budget);
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_done", 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    rst = 1'b1; q_in = '0; sample = 1'b0; tx_ready = 1'b0;
    m_snap = '0; m_flag = 1'b0; m_cnt = 0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_tx_valid", {7'd0, tx_valid}, 8'd0);
    check("reset_busy", {7'd0, busy}, 8'd0);
    check("reset_drop_cnt", drop_cnt, 8'h00);
    @(posedge clk); #1;

    // First frame: header is popcount against an all-zero reference.
    tx_ready = 1'b1;
    pulse_sample(64'h0000_0000_0000_00FF);
    check("first_header", 8'(exp_q[0]), 8'h08);
    drain(20);
    check("first_frame_cycles", 8'(n), 8'd9);
    step();

    pulse_sample(64'h0000_0000_0000_01FE);
    check("second_header", 8'(exp_q[0]), 8'h02);
    drain(20);

    // Alternating ready starting stalled: nine transfers take 18 cycles.
    q_in = 64'h0123_4567_89AB_CDEF;
    pulse_sample(q_in);
    n = 0;
    tx_ready = 1'b0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
      tx_ready = ~tx_ready;
    end
    check("toggle_cycles", 8'(n), 8'd18);
    tx_ready = 1'b1;

    // Three drops in one frame, then a sample on the final transfer cycle.
    pulse_sample(64'hFFFF_0000_FFFF_0000);
    for (int i = 0; i < 3; i++) begin
      step();
      pulse_sample(64'hDEAD_BEEF_0000_0001);
    end
    drain(20);
    check("drop_cnt_three", drop_cnt, 8'd3);
    pulse_sample(64'h8000_0000_0000_0001);
    check("flag_set_header_bit7", {7'd0, exp_q[0][7]}, 8'd1);
    drain(20);
    pulse_sample(64'h0000_0000_0000_0000);
    check("flag_clear_header_bit7", {7'd0, exp_q[0][7]}, 8'd0);
    while (exp_q.size() > 1 && n < 200) begin
      step();
      n++;
    end
    pulse_sample(64'h1111_2222_3333_4444);
    step();
    check("drop_on_final_xfer", drop_cnt, 8'd4);

    // Permanently stalled frame: drop counter saturates.
    tx_ready = 1'b0;
    pulse_sample(64'hA5A5_5A5A_A5A5_5A5A);
    sample = 1'b1;
    for (int i = 0; i < 300; i++) step();
    sample = 1'b0;
    step();
    check("drop_cnt_saturated", drop_cnt, 8'hFF);
    tx_ready = 1'b1;
    drain(20);

    // Reset mid-frame after four bytes; sample during reset is ignored.
    pulse_sample(64'h0F0F_0F0F_0F0F_0F0F);
    for (int i = 0; i < 4; i++) step();
    rst    = 1'b1;
    sample = 1'b1;
    step();
    rst    = 1'b0;
    sample = 1'b0;
    step();
    check("abort_drop_cnt", drop_cnt, 8'h00);
    pulse_sample(64'h0000_0000_0000_0F0F);
    check("post_reset_header", 8'(exp_q[0]), 8'h08);
    drain(20);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dff_bank_monitor.md
DFF_BANK_MONITOR -- requirements
Module: dff_bank_monitor

Interface
REQ-001 SHALL have parameter Q_WIDTH, default 64, width of the monitored DFF output bank; fixed at 64 (8 bytes).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port q_in  input  64  DFF bank outputs being monitored.
REQ-005 SHALL have port sample  input  1  single-cycle request to snapshot q_in.
REQ-006 SHALL have port tx_data  output  8  current frame byte.
REQ-007 SHALL have port tx_valid  output  1  tx_data is valid.
REQ-008 SHALL have port tx_ready  input  1  consumer accepts tx_data this cycle.
REQ-009 SHALL have port busy  output  1  a frame is in progress.
REQ-010 SHALL have port drop_cnt  output  8  count of dropped samples, saturating.

Function
REQ-011 SHALL implement FSM states IDLE, HEADER, DATA.
REQ-012 In IDLE with sample=1: SHALL latch q_in into snap and snap into prev; header = popcount(q_in ^ prev) in bits 6:0 (0..64); bit 7 = dropped-since-last-frame flag; go to HEADER.
REQ-013 tx_valid SHALL assert the cycle after sample is accepted (latency 1); busy = (state != IDLE).
REQ-014 Byte transfers only on cycles with tx_valid && tx_ready; tx_data and tx_valid SHALL hold stable while tx_ready=0.
REQ-015 HEADER: after transfer, go to DATA with byte index 0.
REQ-016 DATA: tx_data = snap[8*idx+7 : 8*idx]; idx increments per transfer; after idx=7 transfers, return to IDLE, tx_valid deasserts the same edge.
REQ-017 A frame is exactly 9 bytes; minimum 10 cycles from sample to next possible acceptance with tx_ready held high.
REQ-018 sample while busy SHALL be dropped: drop_cnt increments, saturating at 255; sticky drop flag set.
REQ-019 Drop flag SHALL clear when copied into a header; drop_cnt clears only on rst.
REQ-020 sample on the same cycle as the final DATA transfer SHALL count as dropped (FSM still busy that cycle).
REQ-021 prev after reset SHALL be all zeros; the first header is therefore popcount(q_in).

Reset
REQ-022 rst=1 on a clk edge SHALL force: state IDLE, tx_valid 0, tx_data 0x00, busy 0, drop_cnt 0, drop flag 0, snap 0, prev 0, idx 0.
REQ-023 rst mid-frame SHALL abort the frame with no further bytes; sample in the reset cycle is ignored and not counted.

Structure
REQ-024 Shared package dff_mon_pkg SHALL hold Q_WIDTH, NUM_BYTES (8), FRAME_LEN (9), DROP_MAX (255) and the state enum type.
REQ-025 Popcount SHALL be a separate sub-module popcount64 (64-bit in, 7-bit out, purely combinational).
REQ-026 Design SHALL be purely synchronous to clk; no latches, no derived clocks.

Verification
REQ-027 After reset, q_in=64'h0000_0000_0000_00FF, sample pulse, tx_ready=1 -> bytes 0x08, 0xFF, then seven 0x00; busy low 10 cycles after sample.
REQ-028 Then q_in=64'h0000_0000_0000_01FE, sample -> header 0x02 (bits 0 and 8 changed), data bytes 0xFE, 0x01, six 0x00.
REQ-029 tx_ready toggled 1/0 each cycle during a frame -> tx_data stable while stalled, 9 bytes delivered unchanged, 18 cycles.
REQ-030 Three sample pulses during a frame -> drop_cnt=3; next frame header bit 7 = 1; following frame bit 7 = 0.
REQ-031 300 samples while permanently stalled (tx_ready=0) -> drop_cnt saturates at 0xFF.
REQ-032 rst asserted after 4 transferred bytes -> tx_valid=0, busy=0 next cycle; next frame header = popcount(q_in) vs zero prev.
